// File: rtl/instr_fetch_queue_pkg.sv
// Shared core-pipeline definitions used by the fetch queue and its FIFO.
package instr_fetch_queue_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Bundles the fetch control, instruction-memory, redirect and decode-side signals of the fetch queue.
interface instr_fetch_queue_if #(
    parameter int DEPTH = 4
) ();

    logic                       fetch_en;
    logic                       imem_req;
    logic [31:0]                imem_addr;
    logic [31:0]                imem_rdata;
    logic                       redirect_valid;
    logic [31:0]                redirect_pc;
    logic                       id_valid;
    logic [31:0]                id_instr;
    logic [31:0]                id_pc;
    logic                       id_ready;
    logic [$clog2(DEPTH+1)-1:0] q_count;

    modport master (
        input  fetch_en, imem_rdata, redirect_valid, redirect_pc, id_ready,
        output imem_req, imem_addr, id_valid, id_instr, id_pc, q_count
    );

    modport slave (
        output fetch_en, imem_rdata, redirect_valid, redirect_pc, id_ready,
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, q_count
    );

endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// Synchronous DEPTH-entry FIFO of fetch entries; flush clears it in one cycle.
module ifq_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           do_push;
    logic           do_pop;

    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count != CW'(DEPTH)) | do_pop);

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

    assign head = (count != '0) ? mem[rptr] : '0;

endmodule

// File: rtl/instr_fetch_queue.sv
// Owns the PC, issues word fetches to a sync-read imem and buffers returned instructions for decode.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] infl_pc;
    logic            infl_valid;
    logic [CW-1:0]   count;
    logic [CW:0]     credit;
    logic            push;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // The in-flight word is counted as occupied, so a granted request always has a free slot.
    assign credit       = {1'b0, count} + {{CW{1'b0}}, infl_valid};
    assign bus.imem_req = bus.fetch_en & ~rst & ~bus.redirect_valid & (credit < DEPTH_C);
    assign bus.imem_addr = pc_q;

    assign push             = infl_valid & ~bus.redirect_valid & ~rst;
    assign push_entry.pc    = infl_pc;
    assign push_entry.instr = bus.imem_rdata;

    assign bus.id_valid = (count != '0) & ~bus.redirect_valid & ~rst;
    assign pop          = bus.id_valid & bus.id_ready;
    assign bus.id_instr = head.instr;
    assign bus.id_pc    = head.pc;
    assign bus.q_count  = rst ? '0 : count;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            infl_valid <= 1'b0;
            infl_pc    <= '0;
        end else if (bus.redirect_valid) begin
            pc_q       <= bus.redirect_pc & ~32'd3;
            infl_valid <= 1'b0;
        end else begin
            infl_valid <= bus.imem_req;
            if (bus.imem_req) begin
                pc_q    <= pc_q + 32'd4;
                infl_pc <= pc_q;
            end
        end
    end

    ifq_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

endmodule
